// File: rtl/pkt_rx_wr_pkg.sv
// Shared definitions for the packet receive writer and the downstream scheduler:
// FSM encoding, default sizing constants and the descriptor layout.
package pkt_rx_wr_pkg;

  // Default RAM address width (2048 words) and longest packet in words.
  localparam int unsigned PKT_RAM_DEPTH = 11;
  localparam int unsigned PKT_MAX_LEN   = 1023;

  // Descriptor layout: {3'b000, len[9:0], start[10:0]}.
  localparam int unsigned DESC_W         = 24;
  localparam int unsigned DESC_START_LSB = 0;
  localparam int unsigned DESC_START_W   = 11;
  localparam int unsigned DESC_LEN_LSB   = 11;
  localparam int unsigned DESC_LEN_W     = 10;

  typedef logic [DESC_W-1:0] desc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DROP   = 2'd3
  } rx_state_e;

  // Build a descriptor word from a length and a start address.
  function automatic desc_t pack_desc(input logic [DESC_LEN_W-1:0]   len,
                                      input logic [DESC_START_W-1:0] start);
    desc_t d;
    d = '0;
    d[DESC_LEN_LSB +: DESC_LEN_W]     = len;
    d[DESC_START_LSB +: DESC_START_W] = start;
    return d;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pkt_rx_wr.sv
// Packet receive writer: accepts framed 16-bit words, stores whole packets into a
// ring buffer RAM and emits one descriptor per committed packet. Packets that do
// not fit, are too long, or are cut short by a new sof are dropped and counted.
module pkt_rx_wr
  import pkt_rx_wr_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = PKT_RAM_DEPTH,
  parameter int unsigned MAX_LEN   = PKT_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:15]          rx_data,
  input  logic                 rx_sof_n,
  input  logic                 rx_eof_n,
  input  logic                 rx_src_rdy_n,
  output logic                 rx_dst_rdy_n,
  output logic                 ram_wen,
  output logic [RAM_DEPTH-1:0] ram_waddr,
  output logic [15:0]          ram_din,
  input  logic [RAM_DEPTH-1:0] ram_rd_ptr,
  output logic                 desc_wren,
  output logic [DESC_W-1:0]    desc_din,
  input  logic                 desc_full,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  localparam logic [RAM_DEPTH-1:0] PtrOne = RAM_DEPTH'(1);
  localparam logic [LenW-1:0]      LenOne = LenW'(1);
  localparam logic [LenW-1:0]      LenMax = LenW'(MAX_LEN);

  rx_state_e state_q, state_d;

  logic [RAM_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_DEPTH-1:0] start_q, start_d;
  logic [LenW-1:0]      len_q, len_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 rx_dst_rdy_n_q, rx_dst_rdy_n_d;
  logic                 ram_wen_q, ram_wen_d;
  logic [RAM_DEPTH-1:0] ram_waddr_q, ram_waddr_d;
  logic [15:0]          ram_din_q, ram_din_d;
  logic                 desc_wren_q, desc_wren_d;
  desc_t                desc_din_q, desc_din_d;

  logic                 sof, eof, accept;
  logic [RAM_DEPTH-1:0] sof_base;
  logic [RAM_DEPTH-1:0] sof_free;
  logic                 sof_ok;
  logic                 sof_take;

  assign sof    = ~rx_sof_n;
  assign eof    = ~rx_eof_n;
  assign accept = ~rx_src_rdy_n & ~rx_dst_rdy_n_q;

  // A sof inside a packet restarts from the aborted packet's start address, so
  // the space check must use the rewound pointer rather than wr_ptr.
  assign sof_base = (state_q == ST_WRITE) ? start_q : wr_ptr_q;
  assign sof_free = ram_rd_ptr - sof_base - PtrOne;
  assign sof_ok   = (32'(sof_free) >= MAX_LEN) && !desc_full;

  // Next-state and next-output decode for the receive FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_d     = start_q;
    len_d       = len_q;
    drop_cnt_d  = drop_cnt_q;
    ram_wen_d   = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_din_d   = ram_din_q;
    desc_wren_d = 1'b0;
    desc_din_d  = desc_din_q;
    sof_take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Non-sof beats in idle are swallowed without a write.
        sof_take = accept & sof;
      end
      ST_WRITE: begin
        if (accept) begin
          if (sof) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            sof_take   = 1'b1;
          end else if (len_q == LenMax) begin
            wr_ptr_d   = start_q;
            drop_cnt_d = sat_inc16(drop_cnt_q);
            state_d    = eof ? ST_IDLE : ST_DROP;
          end else begin
            ram_wen_d   = 1'b1;
            ram_waddr_d = wr_ptr_q;
            ram_din_d   = rx_data;
            wr_ptr_d    = wr_ptr_q + PtrOne;
            len_d       = len_q + LenOne;
            if (eof) begin
              state_d     = ST_COMMIT;
              desc_wren_d = 1'b1;
              desc_din_d  = pack_desc(DESC_LEN_W'(len_d), DESC_START_W'(start_q));
            end
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      ST_DROP: begin
        // sof is ignored here; only eof ends the discarded packet.
        if (accept && eof) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Packet-accept decision for a sof beat, shared by idle and mid-packet restart.
    if (sof_take) begin
      start_d = sof_base;
      if (sof_ok) begin
        ram_wen_d   = 1'b1;
        ram_waddr_d = sof_base;
        ram_din_d   = rx_data;
        wr_ptr_d    = sof_base + PtrOne;
        len_d       = LenOne;
        if (eof) begin
          state_d     = ST_COMMIT;
          desc_wren_d = 1'b1;
          desc_din_d  = pack_desc(DESC_LEN_W'(1), DESC_START_W'(sof_base));
        end else begin
          state_d = ST_WRITE;
        end
      end else begin
        wr_ptr_d   = sof_base;
        drop_cnt_d = sat_inc16(drop_cnt_d);
        state_d    = eof ? ST_IDLE : ST_DROP;
      end
    end

    // Back-pressure only during the single commit cycle.
    rx_dst_rdy_n_d = (state_d == ST_COMMIT);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      start_q        <= '0;
      len_q          <= '0;
      drop_cnt_q     <= '0;
      rx_dst_rdy_n_q <= 1'b1;
      ram_wen_q      <= 1'b0;
      ram_waddr_q    <= '0;
      ram_din_q      <= '0;
      desc_wren_q    <= 1'b0;
      desc_din_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      start_q        <= start_d;
      len_q          <= len_d;
      drop_cnt_q     <= drop_cnt_d;
      rx_dst_rdy_n_q <= rx_dst_rdy_n_d;
      ram_wen_q      <= ram_wen_d;
      ram_waddr_q    <= ram_waddr_d;
      ram_din_q      <= ram_din_d;
      desc_wren_q    <= desc_wren_d;
      desc_din_q     <= desc_din_d;
    end
  end

  assign rx_dst_rdy_n = rx_dst_rdy_n_q;
  assign ram_wen      = ram_wen_q;
  assign ram_waddr    = ram_waddr_q;
  assign ram_din      = ram_din_q;
  assign desc_wren    = desc_wren_q;
  assign desc_din     = desc_din_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_pkt_rx_wr.sv
// Self-checking bench for pkt_rx_wr: table of packets plus hand-written corner
// sequences; RAM writes and descriptors are checked against a scoreboard.
module tb_pkt_rx_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_data;
  logic        rx_sof_n, rx_eof_n, rx_src_rdy_n;
  logic        rx_dst_rdy_n;
  logic        ram_wen;
  logic [10:0] ram_waddr;
  logic [15:0] ram_din;
  logic [10:0] ram_rd_ptr;
  logic        desc_wren;
  logic [23:0] desc_din;
  logic        desc_full;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  int exp_drops = 0;

  logic [26:0] exp_wr[$];
  logic [23:0] exp_desc[$];

  typedef struct {
    logic [10:0] rd;
    bit          full;
    int          n;
    logic [15:0] d0;
    bit          drop;
    logic [10:0] start;
  } row_t;

  row_t rows[8];

  pkt_rx_wr #(
    .RAM_DEPTH(11),
    .MAX_LEN  (1023)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_sof_n    (rx_sof_n),
    .rx_eof_n    (rx_eof_n),
    .rx_src_rdy_n(rx_src_rdy_n),
    .rx_dst_rdy_n(rx_dst_rdy_n),
    .ram_wen     (ram_wen),
    .ram_waddr   (ram_waddr),
    .ram_din     (ram_din),
    .ram_rd_ptr  (ram_rd_ptr),
    .desc_wren   (desc_wren),
    .desc_din    (desc_din),
    .desc_full   (desc_full),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every RAM write and descriptor must match the oldest expectation.
  always @(negedge clk) begin
    if (ram_wen === 1'b1) begin
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected ram write: addr %0d data %0h, none expected",
                 ram_waddr, ram_din);
      end else begin
        check("ram write {addr,data}", {5'b0, ram_waddr, ram_din}, {5'b0, exp_wr.pop_front()});
      end
    end
    if (desc_wren === 1'b1) begin
      if (exp_desc.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected descriptor: %0h, none expected", desc_din);
      end else begin
        check("descriptor", {8'b0, desc_din}, {8'b0, exp_desc.pop_front()});
      end
    end
  end

  // Drive one beat and hold it until the DUT takes it; returns #1 after the accepting edge.
  task automatic send_beat(input logic [15:0] d, input bit sof, input bit eof);
    int n;
    n = 0;
    rx_data      = d;
    rx_sof_n     = ~sof;
    rx_eof_n     = ~eof;
    rx_src_rdy_n = 1'b0;
    while (rx_dst_rdy_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL ready timeout: rx_dst_rdy_n %b after 20 cycles, required 0", rx_dst_rdy_n);
    end
    @(posedge clk);
    #1;
    rx_src_rdy_n = 1'b1;
    rx_sof_n     = 1'b1;
    rx_eof_n     = 1'b1;
  endtask

  // Send n words; the first nwr are expected to be written from 'start' onward.
  task automatic send_pkt(input logic [10:0] start, input int n, input logic [15:0] d0,
                          input bit eof_last, input int nwr, input bit want_desc);
    for (int i = 0; i < n; i++) begin
      logic [10:0] a;
      a = start + 11'(i);
      if (i < nwr) exp_wr.push_back({a, d0 + 16'(i)});
      if (want_desc && i == n - 1) exp_desc.push_back({3'b000, 10'(n), start});
      send_beat(d0 + 16'(i), i == 0, eof_last && (i == n - 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{11'd0,    1'b0, 4,    16'hAAAA, 1'b0, 11'd0};
    rows[1] = '{11'd0,    1'b0, 1,    16'h1000, 1'b0, 11'd4};
    rows[2] = '{11'd0,    1'b1, 3,    16'h2000, 1'b1, 11'd5};
    rows[3] = '{11'd506,  1'b0, 3,    16'h3000, 1'b1, 11'd5};  // free = 500
    rows[4] = '{11'd0,    1'b0, 2,    16'h4000, 1'b0, 11'd5};
    rows[5] = '{11'd0,    1'b0, 1023, 16'h5000, 1'b0, 11'd7};
    rows[6] = '{11'd1030, 1'b0, 1010, 16'h6000, 1'b0, 11'd1030};
    rows[7] = '{11'd2040, 1'b0, 10,   16'h7000, 1'b0, 11'd2040};  // wraps 2047 -> 0

    rst          = 1'b0;
    rx_data      = '0;
    rx_sof_n     = 1'b1;
    rx_eof_n     = 1'b1;
    rx_src_rdy_n = 1'b1;
    ram_rd_ptr   = '0;
    desc_full    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rx_dst_rdy_n", rx_dst_rdy_n, 1);
    check("reset ram_wen", ram_wen, 0);
    check("reset desc_wren", desc_wren, 0);
    check("reset ram_waddr", ram_waddr, 0);
    check("reset ram_din", ram_din, 0);
    check("reset desc_din", desc_din, 0);
    check("reset drop_cnt", drop_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      ram_rd_ptr = rows[r].rd;
      desc_full  = rows[r].full;
      if (rows[r].drop) begin
        send_pkt(rows[r].start, rows[r].n, rows[r].d0, 1'b1, 0, 1'b0);
        exp_drops++;
      end else begin
        send_pkt(rows[r].start, rows[r].n, rows[r].d0, 1'b1, rows[r].n, 1'b1);
        check("desc_wren cycle after eof", desc_wren, 1);
        check("rx_dst_rdy_n in commit", rx_dst_rdy_n, 1);
        if (r == 0) check("first descriptor value", desc_din, 24'h002000);
      end
      desc_full = 1'b0;
      repeat (3) @(negedge clk);
      check("drop_cnt after table row", drop_cnt, exp_drops);
    end

    // Over-length packet: 1023 words land, word 1024 aborts and rewinds to start 2.
    ram_rd_ptr = 11'd2;
    send_pkt(11'd2, 1024, 16'h8000, 1'b1, 1023, 1'b0);
    exp_drops++;
    repeat (3) @(negedge clk);
    check("drop_cnt after over-length", drop_cnt, exp_drops);
    send_pkt(11'd2, 2, 16'h9000, 1'b1, 2, 1'b1);
    repeat (3) @(negedge clk);

    // sof after 5 words: old packet dropped, new one reuses start 4.
    send_pkt(11'd4, 5, 16'hB000, 1'b0, 5, 1'b0);
    send_pkt(11'd4, 3, 16'hC000, 1'b1, 3, 1'b1);
    exp_drops++;
    repeat (3) @(negedge clk);
    check("drop_cnt after mid-packet sof", drop_cnt, exp_drops);

    // Beats without sof in idle are discarded.
    send_beat(16'hDEAD, 1'b0, 1'b0);
    send_beat(16'hBEEF, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("drop_cnt after stray beats", drop_cnt, exp_drops);

    // Reset mid-packet: no descriptor, write pointer back to 0.
    send_pkt(11'd7, 3, 16'hE000, 1'b0, 3, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid reset rx_dst_rdy_n", rx_dst_rdy_n, 1);
    check("mid reset ram_wen", ram_wen, 0);
    check("mid reset ram_waddr", ram_waddr, 0);
    check("mid reset drop_cnt", drop_cnt, 0);
    exp_drops = 0;
    rst = 1'b1;
    @(negedge clk);
    ram_rd_ptr = '0;
    send_pkt(11'd0, 1, 16'hF000, 1'b1, 1, 1'b1);
    check("desc_wren after single-beat", desc_wren, 1);

    repeat (5) @(negedge clk);
    check("outstanding expected writes", exp_wr.size(), 0);
    check("outstanding expected descriptors", exp_desc.size(), 0);
    check("final drop_cnt", drop_cnt, exp_drops);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
